// File: rtl/x_encoder_pkg.sv
// Shared types and constants for the quadrature encoder generator:
// FSM state encoding, the phase-to-AB lookup and the default minimum step period.
package x_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STEP,
    ST_DONE
  } state_t;

  localparam int unsigned MIN_PERIOD_DEFAULT = 2;

  // Entry [n] is {A,B} for phase n; walking up the table is a forward count.
  localparam logic [3:0][1:0] AB_TABLE = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
    return AB_TABLE[phase];
  endfunction

endpackage

// File: rtl/x_encoder_gen_if.sv
// Move-command handshake between a motion controller (master) and the
// encoder generator (slave).
interface x_encoder_gen_if;

  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic signed [31:0] cmd_target_i;
  logic        [15:0] step_period_i;

  modport master (
    output cmd_valid_i,
    output cmd_target_i,
    output step_period_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i,
    input  cmd_target_i,
    input  step_period_i,
    output cmd_ready_o
  );

endinterface

// File: rtl/x_encoder_step_timer.sv
// Step period counter: cleared by load, counts while run is high and flags
// expire on the last clock of a period.
module x_encoder_step_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        run,
  input  logic [15:0] period,
  output logic        expire
);

  logic [15:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (run) begin
      count <= count + 16'd1;
    end
  end

  // period is never below 2, so period-1 cannot underflow.
  assign expire = run && (count == period - 16'd1);

endmodule

// File: rtl/x_encoder_gen.sv
// Quadrature encoder generator: steps a position counter toward a commanded
// target and emits A/B (and optional Z) edges. Define X_ENCODER_Z_INDEX_EN to enable Z.
module x_encoder_gen
  import x_encoder_pkg::*;
#(
  parameter int unsigned PPR_LOG2   = 12,
  parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  x_encoder_gen_if.slave     cmd,
  input  logic               zero_calib_i,
  output logic               enc_a_o,
  output logic               enc_b_o,
  output logic               enc_z_o,
  output logic signed [31:0] pos_o,
  output logic               busy_o,
  output logic               done_o
);

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_sync_n = rst_pipe[1];

  logic [2:0] calib_q;
  logic       calib_edge;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) calib_q <= '0;
    else             calib_q <= {calib_q[1:0], zero_calib_i};
  end

  assign calib_edge = calib_q[1] & ~calib_q[2];

  state_t             state;
  logic signed [31:0] pos;
  logic signed [31:0] target;
  logic        [15:0] period_q;
  logic        [1:0]  phase;
  logic        [1:0]  ab_q;
  logic               done_q;

  logic               accept;
  logic        [15:0] period_clamped;
  logic signed [31:0] diff;
  logic signed [31:0] pos_next;
  logic        [1:0]  phase_next;
  logic               timer_load;
  logic               timer_expire;

  assign cmd.cmd_ready_o = (state == ST_IDLE) && !calib_edge;
  assign accept          = cmd.cmd_valid_i && cmd.cmd_ready_o;
  assign timer_load      = accept || (state == ST_STEP);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    period_clamped = cmd.step_period_i;
    if (cmd.step_period_i < 16'(MIN_PERIOD)) period_clamped = 16'(MIN_PERIOD);
    diff       = target - pos;
    pos_next   = pos - 32'sd1;
    phase_next = phase - 2'd1;
    if (diff > 0) begin
      pos_next   = pos + 32'sd1;
      phase_next = phase + 2'd1;
    end
  end

  x_encoder_step_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_sync_n),
    .load   (timer_load),
    .run    (state == ST_WAIT),
    .period (period_q),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state    <= ST_IDLE;
      pos      <= '0;
      target   <= '0;
      period_q <= 16'(MIN_PERIOD);
      phase    <= 2'd0;
      ab_q     <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      unique case (state)
        ST_IDLE: begin
          // Calibration has priority; the command simply stays pending.
          if (calib_edge) begin
            pos <= '0;
          end else if (cmd.cmd_valid_i) begin
            target   <= cmd.cmd_target_i;
            period_q <= period_clamped;
            state    <= (cmd.cmd_target_i == pos) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (timer_expire) state <= ST_STEP;
        end
        ST_STEP: begin
          pos   <= pos_next;
          phase <= phase_next;
          ab_q  <= phase_to_ab(phase_next);
          state <= (pos_next == target) ? ST_DONE : ST_WAIT;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef X_ENCODER_Z_INDEX_EN
  logic z_q;

  // Tracks pos so the index pulse lines up with the A/B edge that reaches it.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      z_q <= 1'b1;
    end else if ((state == ST_IDLE) && calib_edge) begin
      z_q <= 1'b1;
    end else if (state == ST_STEP) begin
      z_q <= (pos_next[PPR_LOG2-1:0] == '0);
    end
  end

  assign enc_z_o = z_q;
`else
  assign enc_z_o = 1'b0;
`endif

  assign enc_a_o = ab_q[1];
  assign enc_b_o = ab_q[0];
  assign pos_o   = pos;
  assign busy_o  = (state != ST_IDLE);
  assign done_o  = done_q;

endmodule

// File: tb/tb_x_encoder_gen.sv
// Randomised self-checking bench for x_encoder_gen against a position/phase
// model; compile with X_ENCODER_Z_INDEX_EN to also check the index output.
module tb_x_encoder_gen;

  localparam int PPR = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               zero_calib = 1'b0;
  logic               enc_a, enc_b, enc_z;
  logic signed [31:0] pos;
  logic               busy, done;

  x_encoder_gen_if bus ();

  x_encoder_gen #(.PPR_LOG2(PPR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (bus),
    .zero_calib_i (zero_calib),
    .enc_a_o      (enc_a),
    .enc_b_o      (enc_b),
    .enc_z_o      (enc_z),
    .pos_o        (pos),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic signed [31:0] m_pos = 0;
  int                 m_phase = 0;

  function automatic logic [1:0] exp_ab(input int ph);
    case (ph & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic exp_z();
`ifdef X_ENCODER_Z_INDEX_EN
    logic signed [31:0] p;
    p = m_pos;
    return (p[PPR-1:0] == '0);
`else
    return 1'b0;
`endif
  endfunction

  // Entered at the negedge just after the accepting clock edge.
  task automatic monitor_move(input logic signed [31:0] tgt, input int pc);
    logic signed [31:0] d;
    int n_exp, done_cyc, edges, step;
    bit got_done;
    d        = tgt - m_pos;
    n_exp    = (d < 0) ? -d : d;
    done_cyc = (n_exp == 0) ? 1 : n_exp * (pc + 1) + 1;
    edges    = 0;
    got_done = 0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_at_accept: got %b want 1", busy);
    end
    for (int cyc = 1; cyc <= done_cyc + 3 && !got_done; cyc++) begin
      @(negedge clk);
      if ({enc_a, enc_b} !== exp_ab(m_phase)) begin
        edges++;
        step    = ((tgt - m_pos) > 0) ? 1 : -1;
        m_pos   = m_pos + step;
        m_phase = (m_phase + step) & 3;
        checks++;
        if (cyc != edges * (pc + 1)) begin
          errors++; $display("FAIL edge_time: edge %0d at cycle %0d want %0d", edges, cyc, edges * (pc + 1));
        end
        checks++;
        if ({enc_a, enc_b} !== exp_ab(m_phase)) begin
          errors++; $display("FAIL ab_value: got %b want %b", {enc_a, enc_b}, exp_ab(m_phase));
        end
      end
      checks++;
      if (pos !== m_pos || enc_z !== exp_z()) begin
        errors++; $display("FAIL pos_track: cycle %0d pos %0d z %b want pos %0d z %b", cyc, pos, enc_z, m_pos, exp_z());
      end
      if (done === 1'b1) begin
        got_done = 1;
        checks++;
        if (cyc != done_cyc || edges != n_exp || pos !== tgt || busy !== 1'b0) begin
          errors++;
          $display("FAIL move_done: cycle %0d edges %0d pos %0d busy %b want cycle %0d edges %0d pos %0d busy 0",
                   cyc, edges, pos, busy, done_cyc, n_exp, tgt);
        end
      end
    end
    if (!got_done) begin
      errors++; checks++;
      $display("FAIL done_timeout: no done_o within %0d cycles", done_cyc + 3);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_width: got %b want 0", done);
    end
  endtask

  task automatic do_move(input logic signed [31:0] tgt, input logic [15:0] per);
    int pc;
    pc = (per < 2) ? 2 : int'(per);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL ready_idle: got %b want 1", bus.cmd_ready_o);
    end
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_target_i  = tgt;
    bus.step_period_i = per;
    @(negedge clk);
    bus.cmd_valid_i   = 1'b0;
    bus.cmd_target_i  = $urandom;
    bus.step_period_i = 16'($urandom);
    monitor_move(tgt, pc);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({enc_a, enc_b} !== 2'b00 || pos !== 0 || busy !== 1'b0 || done !== 1'b0 || enc_z !== exp_z()) begin
      errors++; $display("FAIL reset_state: ab %b pos %0d busy %b done %b z %b", {enc_a, enc_b}, pos, busy, done, enc_z);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cmd_ready_o !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready %b busy %b want 1 0", bus.cmd_ready_o, busy);
    end
  endtask

  task automatic test_moves();
    do_move(32'sd4, 16'd3);
    do_move(32'sd1, 16'd3);
    do_move(32'sd3, 16'd0);
    do_move(-32'sd9, 16'd1);
  endtask

  task automatic test_zero_move();
    do_move(m_pos, 16'd5);
  endtask

  task automatic test_calib();
    logic [1:0] ab_before;
    do_move(32'sd7, 16'd2);
    ab_before = exp_ab(m_phase);
    @(negedge clk);
    zero_calib = 1'b1;
    repeat (4) @(negedge clk);
    m_pos = 0;
    checks++;
    if (pos !== 0 || {enc_a, enc_b} !== ab_before || enc_z !== exp_z() || busy !== 1'b0) begin
      errors++; $display("FAIL calib_idle: pos %0d ab %b z %b busy %b want 0 %b %b 0", pos, {enc_a, enc_b}, enc_z, busy, ab_before, exp_z());
    end
    zero_calib = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_calib_collision();
    do_move(32'sd5, 16'd2);
    @(negedge clk);
    zero_calib = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready_o !== 1'b0) begin
      errors++; $display("FAIL ready_on_calib: got %b want 0", bus.cmd_ready_o);
    end
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_target_i  = 32'sd3;
    bus.step_period_i = 16'd2;
    @(negedge clk);
    checks++;
    if (pos !== 0 || busy !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL calib_first: pos %0d busy %b ready %b want 0 0 1", pos, busy, bus.cmd_ready_o);
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    m_pos = 0;
    monitor_move(32'sd3, 2);
    zero_calib = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_calib_busy();
    logic signed [31:0] tgt;
    tgt = m_pos + 6;
    @(negedge clk);
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_target_i  = tgt;
    bus.step_period_i = 16'd4;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    fork
      monitor_move(tgt, 4);
      begin
        repeat (2) @(negedge clk);
        zero_calib = 1'b1;
        repeat (4) @(negedge clk);
        zero_calib = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    checks++;
    if (pos !== tgt) begin
      errors++; $display("FAIL calib_busy_ignored: pos %0d want %0d", pos, tgt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      do_move(m_pos + int'($urandom_range(0, 12)) - 6, 16'($urandom_range(0, 5)));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_target_i  = m_pos + 100;
    bus.step_period_i = 16'd2;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    m_pos = 0;
    m_phase = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pos !== 0 || {enc_a, enc_b} !== 2'b00 || enc_z !== exp_z()) begin
      errors++; $display("FAIL reset_mid: busy %b done %b pos %0d ab %b z %b", busy, done, pos, {enc_a, enc_b}, enc_z);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL reset_no_done: got %b want 0", done);
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_move(-32'sd2, 16'd2);
  endtask

  initial begin
    bus.cmd_valid_i   = 1'b0;
    bus.cmd_target_i  = '0;
    bus.step_period_i = '0;
    test_reset();
    test_moves();
    test_zero_move();
    test_calib();
    test_calib_collision();
    test_calib_busy();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/x_encoder_gen.md
X_ENCODER_GEN -- requirements
Module: x_encoder_gen

Interface
REQ-001 Parameter PPR_LOG2, default 12: index (Z) period is 2^PPR_LOG2 counts.
REQ-002 Parameter MIN_PERIOD, default 2: lower clamp on step_period_i.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid_i  in  1  move command valid.
REQ-006 cmd_ready_o  out  1  block accepts a command.
REQ-007 cmd_target_i  in  32  signed absolute target count.
REQ-008 step_period_i  in  16  clocks between successive quadrature edges.
REQ-009 zero_calib_i  in  1  level input; its rising edge zeroes the position counter.
REQ-010 enc_a_o, enc_b_o  out  1 each  registered quadrature outputs.
REQ-011 enc_z_o  out  1  registered index output.
REQ-012 pos_o  out  32  signed current position count.
REQ-013 busy_o  out  1  move in progress.
REQ-014 done_o  out  1  one-cycle pulse at move completion.

Function
REQ-015 A command is accepted on a cycle with cmd_valid_i && cmd_ready_o; cmd_ready_o = (state==IDLE) && !calib_edge.
REQ-016 FSM states are IDLE, WAIT, STEP, DONE.
REQ-017 IDLE->WAIT on accept; target and clamped period (max(step_period_i, MIN_PERIOD)) are latched; the timer is cleared.
REQ-018 WAIT: timer increments each clock; on timer==period-1 go to STEP.
REQ-019 STEP (one cycle): pos +/-1 and phase +/-1 (mod 4), direction = sign of (target - pos), signed compare; then WAIT if pos'!=target, else DONE.
REQ-020 DONE (one cycle): done_o=1, then IDLE.
REQ-021 target==pos at accept: WAIT is skipped, go straight to DONE, no edge emitted; done_o asserts 2 cycles after accept.
REQ-022 Otherwise the first edge appears on enc_a_o/enc_b_o period+1 cycles after accept; later edges follow every period+1 cycles.
REQ-023 Quadrature map phase->(A,B): 0->00, 1->10, 2->11, 3->01; A = ph[0]^ph[1], B = ph[1]. Incrementing phase is a forward count for the companion decoder.
REQ-024 Exactly one of A/B changes per STEP; no other output transitions on A/B.
REQ-025 pos wraps modulo 2^32 (two's complement); direction still comes from the signed difference.
REQ-026 calib_edge is detected after a 2-flop synchroniser plus edge register.
REQ-027 calib_edge in IDLE: pos <= 0, phase unchanged, no A/B edge.
REQ-028 calib_edge outside IDLE is ignored.
REQ-029 calib_edge and cmd_valid_i in the same cycle: calibration wins and the command stays pending.
REQ-030 busy_o = (state != IDLE).
REQ-031 cmd_target_i and step_period_i changes during a move have no effect.

Reset
REQ-032 On rst_n low, asynchronously: state=IDLE, pos=0, phase=0, timer=0, sync flops=0, enc_a/b=0, done_o=0, busy_o=0; enc_z_o=1 if X_ENCODER_Z_INDEX_EN is defined, else 0.
REQ-033 Reset mid-move aborts the move with no done_o pulse.
REQ-034 Reset is released synchronously inside the block, with a 2-flop deassert synchroniser.

Configuration
REQ-035 Macro X_ENCODER_Z_INDEX_EN defined: enc_z_o = (pos[PPR_LOG2-1:0]==0), registered alongside A/B.
REQ-036 Macro X_ENCODER_Z_INDEX_EN undefined: enc_z_o tied 0 and the index compare logic is absent.

Structure
REQ-037 Package x_encoder_pkg holds the FSM state enum, the phase-to-AB table and the MIN_PERIOD default.
REQ-038 Sub-module x_encoder_step_timer is the period counter, with load/expire ports.

Verification
REQ-039 Reset, then cmd target=+4, period=3 -> AB 00,10,11,01,00 with edges every 4 clk; pos_o=4; done_o 1 cycle; busy_o low after.
REQ-040 pos=4, cmd target=1 -> AB reverse sequence, 3 edges, pos_o=1.
REQ-041 period=0 -> clamped to 2, edges every 3 clk.
REQ-042 pos=7, calib pulse in IDLE -> pos_o=0, AB static; with the macro, enc_z_o=1.
REQ-043 Simultaneous calib edge and cmd_valid_i -> calibration first; command accepted next cycle from pos 0.
REQ-044 rst_n low mid-move, target=100 -> all outputs reset immediately; no done_o pulse.
